// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: feeds operand bits LSB first to an external 1-bit ALU and
// assembles the result word. Define ALU_SEQ_B2B_EN to accept a new command in DONE.
module alu_bitserial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_op,
  input  logic             alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and out_y is held stable while out_valid waits.

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    op_d      = op_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_y     = '0;
    busy      = 1'b0;
    alu_a     = 1'b0;
    alu_b     = 1'b0;
    alu_op    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ST_RUN: begin
        busy         = 1'b1;
        alu_a        = a_q[idx_q];
        alu_b        = b_q[idx_q];
        alu_op       = op_q;
        res_d[idx_q] = alu_y;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_y     = res_q;
`ifdef ALU_SEQ_B2B_EN
        in_ready = out_ready;
        if (out_ready) begin
          accept  = in_valid;
          state_d = ST_IDLE;
        end
`else
        if (out_ready) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new command overrides any return to IDLE chosen above.
    if (accept) begin
      a_d     = in_a;
      b_d     = in_b;
      op_d    = in_op;
      idx_d   = '0;
      res_d   = '0;
      state_d = ST_RUN;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq with the team 1-bit ALU modelled beside it.
module tb_alu_bitserial_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         alu_a;
  logic         alu_b;
  logic [1:0]   alu_op;
  logic         alu_y;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         busy;
  state_e       dbg_state;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Team 1-bit ALU: reserved op returns 0.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_XOR:  alu_y = alu_a ^ alu_b;
      default: alu_y = 1'b0;
    endcase
  end

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  bit           active = 1'b0;
  bit           seen_valid = 1'b0;
  int           acc_cyc = 0;
  logic [W-1:0] ma, mb;
  logic [1:0]   mop;
  logic [W-1:0] alu_a_trace = '0;
  logic [W-1:0] last_y = '0;
  int           last_lat = 0;
  int           deliver_cyc = 0;
  int           last_acc_cyc = 0;
  int           n_deliv = 0;
  int           n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Transaction-level model: a command occupies W cycles of bit feeding after its
  // accepting edge, then its result is presented until consumed.
  always @(negedge clk) begin
    int n;
    logic exp_ir;
    if (!rst_n) begin
      active = 1'b0;
      exp_q.delete();
      chk("reset_outputs", 32'({in_ready, out_valid, busy, alu_a, alu_b, alu_op, out_y}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, {W{1'b0}}}));
    end else begin
      if (active) begin
        n = cyc - acc_cyc;
        if (n < W) begin
          chk("run_ctrl", 32'({in_ready, out_valid, busy}), 32'(3'b001));
          chk("run_alu", 32'({alu_a, alu_b, alu_op}), 32'({ma[n], mb[n], mop}));
          alu_a_trace[n] = alu_a;
        end else begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            last_lat   = cyc + 1 - acc_cyc;
          end
`ifdef ALU_SEQ_B2B_EN
          exp_ir = out_ready;
`else
          exp_ir = 1'b0;
`endif
          chk("done_ctrl", 32'({in_ready, out_valid, busy}), 32'({exp_ir, 2'b11}));
          chk("done_alu", 32'({alu_a, alu_b, alu_op}), 32'(0));
          if (exp_q.size() > 0) chk("done_y", 32'(out_y), 32'(exp_q[0]));
          else chk("done_queue_empty", 32'(exp_q.size()), 32'(1));
          if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            last_y      = out_y;
            deliver_cyc = cyc + 1;
            n_deliv     = n_deliv + 1;
            active      = 1'b0;
          end
        end
      end else begin
        chk("idle_ctrl", 32'({in_ready, out_valid, busy, alu_a, alu_b, alu_op}),
            32'(7'b100_0000));
      end
      if (in_valid && in_ready) begin
        active       = 1'b1;
        seen_valid   = 1'b0;
        acc_cyc      = cyc + 1;
        last_acc_cyc = cyc + 1;
        ma           = in_a;
        mb           = in_b;
        mop          = in_op;
        exp_q.push_back(golden(in_a, in_b, in_op));
        n_acc        = n_acc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input bit keep);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int prev);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_deliv > prev) begin ok = 1'b1; break; end
    end
    if (!ok) chk("deliver_timeout", 32'(0), 32'(1));
    #1;
  endtask

  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic [W-1:0] exp_y, input string name);
    int p;
    p = n_deliv;
    send(a, b, op, 1'b0);
    wait_deliv(p);
    chk(name, 32'(last_y), 32'(exp_y));
    chk({name, "_lat"}, 32'(last_lat), 32'(9));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int p;
    int a1;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cmd(8'hF0, 8'h3C, OP_AND, 8'h30, "and_f0_3c");
    run_cmd(8'hAA, 8'hFF, OP_XOR, 8'h55, "xor_aa_ff");
    chk("xor_alu_a_seq", 32'(alu_a_trace), 32'(8'hAA));
    run_cmd(8'hFF, 8'hFF, OP_RSVD, 8'h00, "rsvd_ff_ff");
    run_cmd(8'h12, 8'h81, OP_OR, 8'h93, "or_12_81");
    run_cmd(8'hC3, 8'h5A, OP_AND, 8'h42, "and_c3_5a");
    run_cmd(8'h3C, 8'hA5, OP_XOR, 8'h99, "xor_3c_a5");

    // Result held back for 5 cycles while a second command waits on in_valid.
    out_ready = 1'b0;
    p = n_deliv;
    send(8'h0F, 8'hF5, OP_AND, 1'b1);
    a1 = n_acc;
    in_a = 8'h66; in_b = 8'h0F; in_op = OP_OR;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("stall_valid_timeout", 32'(0), 32'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("stall_no_accept", 32'(n_acc), 32'(a1));
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (n_acc > a1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("stall_accept_timeout", 32'(0), 32'(1));
    #1 in_valid = 1'b0;
    chk("stall_first_y", 32'(last_y), 32'(8'h05));
`ifdef ALU_SEQ_B2B_EN
    chk("b2b_gap", 32'(last_acc_cyc - deliver_cyc), 32'(0));
`else
    chk("idle_gap", 32'(last_acc_cyc - deliver_cyc), 32'(1));
`endif
    wait_deliv(p + 1);
    chk("stall_second_y", 32'(last_y), 32'(8'h6F));
    chk("stall_second_lat", 32'(last_lat), 32'(9));

    // Reset pulse while bit 3 of an OR command is on the ALU.
    p = n_deliv;
    send(8'h55, 8'h0A, OP_OR, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_no_deliver", 32'(n_deliv), 32'(p));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_queue_flushed", 32'(exp_q.size()), 32'(0));
    run_cmd(8'h0F, 8'h30, OP_OR, 8'h3F, "or_after_reset");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
